dma_cfg_master: RTL and testbench

Register-bus initiator that programs and supervises one DMA transfer on the DMA register block.
- Accepts a transfer command over a valid/ready handshake.
- Writes the channel registers in a fixed order.
- Polls the interrupt register until the done bit sets or a poll limit expires.
- Clears the interrupt and returns status over a valid/ready response port.
- Sits between the system controller and the DMA register block; it is the sole driver of that block's addr/wr_en/rd_en/wdata.

---
 rtl/dma_pkg.sv | 24 ++
 rtl/dma_cfg_master_if.sv | 41 ++++
 rtl/dma_cfg_master.sv | 171 +++++++++++++++++
 tb/tb_dma_cfg_master.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dma_pkg.sv
// rtl/dma_pkg.sv - DMA register map, master FSM states and shared defaults
package dma_pkg;

    localparam logic [15:0] REG_INTR     = 16'h0400;
    localparam logic [15:0] REG_CTRL     = 16'h0404;
    localparam logic [15:0] REG_IO_ADDR  = 16'h0408;
    localparam logic [15:0] REG_MEM_ADDR = 16'h040C;
    localparam logic [15:0] REG_EXTRA    = 16'h0410;

    localparam int DMA_DONE_BIT = 0;

    typedef enum logic [3:0] {
        IDLE,
        WR_IO,
        WR_MEM,
        WR_EXTRA,
        WR_CTRL,
        RD_INTR,
        RD_WAIT,
        CLR_INTR,
        RESP
    } dma_state_e;

endpackage

// File: rtl/dma_cfg_master_if.sv
// rtl/dma_cfg_master_if.sv - command, response and register-bus signals of the DMA config master
interface dma_cfg_master_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [DATA_WIDTH-1:0] cmd_ctrl;
    logic [DATA_WIDTH-1:0] cmd_io_addr;
    logic [DATA_WIDTH-1:0] cmd_mem_addr;
    logic [DATA_WIDTH-1:0] cmd_extra;

    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_WIDTH-1:0] rsp_status;
    logic                  rsp_timeout;

    logic [ADDR_WIDTH-1:0] addr;
    logic                  wr_en;
    logic                  rd_en;
    logic [DATA_WIDTH-1:0] wdata;
    logic [DATA_WIDTH-1:0] rdata;

    modport master (
        input  cmd_valid, cmd_ctrl, cmd_io_addr, cmd_mem_addr, cmd_extra,
        output cmd_ready,
        output rsp_valid, rsp_status, rsp_timeout,
        input  rsp_ready,
        output addr, wr_en, rd_en, wdata,
        input  rdata
    );

    modport slave (
        output cmd_valid, cmd_ctrl, cmd_io_addr, cmd_mem_addr, cmd_extra,
        input  cmd_ready,
        input  rsp_valid, rsp_status, rsp_timeout,
        output rsp_ready,
        input  addr, wr_en, rd_en, wdata,
        output rdata
    );
endinterface

// File: rtl/dma_cfg_master.sv
// rtl/dma_cfg_master.sv - programs one DMA transfer, polls for done, clears the interrupt, reports status
module dma_cfg_master
    import dma_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int POLL_LIMIT = 16,
    parameter int DONE_BIT   = DMA_DONE_BIT
) (
    input  logic             clk,
    input  logic             rst_n,
    dma_cfg_master_if.master bus
);

    localparam int               CNT_W   = $clog2(POLL_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(POLL_LIMIT);

    dma_state_e            state_q, state_d;
    logic                  cmd_ready_q, cmd_ready_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0] rsp_status_q, rsp_status_d;
    logic                  rsp_timeout_q, rsp_timeout_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  wr_en_q, wr_en_d;
    logic                  rd_en_q, rd_en_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [CNT_W-1:0]      poll_cnt_q, poll_cnt_d;
    logic [CNT_W-1:0]      poll_cnt_inc;
    logic [DATA_WIDTH-1:0] ctrl_q, ctrl_d;
    logic [DATA_WIDTH-1:0] io_q, io_d;
    logic [DATA_WIDTH-1:0] mem_q, mem_d;
    logic [DATA_WIDTH-1:0] extra_q, extra_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            cmd_ready_q   <= 1'b1;
            rsp_valid_q   <= 1'b0;
            rsp_status_q  <= '0;
            rsp_timeout_q <= 1'b0;
            addr_q        <= '0;
            wr_en_q       <= 1'b0;
            rd_en_q       <= 1'b0;
            wdata_q       <= '0;
            poll_cnt_q    <= '0;
            ctrl_q        <= '0;
            io_q          <= '0;
            mem_q         <= '0;
            extra_q       <= '0;
        end else begin
            state_q       <= state_d;
            cmd_ready_q   <= cmd_ready_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_status_q  <= rsp_status_d;
            rsp_timeout_q <= rsp_timeout_d;
            addr_q        <= addr_d;
            wr_en_q       <= wr_en_d;
            rd_en_q       <= rd_en_d;
            wdata_q       <= wdata_d;
            poll_cnt_q    <= poll_cnt_d;
            ctrl_q        <= ctrl_d;
            io_q          <= io_d;
            mem_q         <= mem_d;
            extra_q       <= extra_d;
        end
    end

    assign poll_cnt_inc = (poll_cnt_q == CNT_MAX) ? poll_cnt_q : poll_cnt_q + CNT_W'(1);

    // Next state and captured command/status
    always_comb begin
        state_d       = state_q;
        rsp_status_d  = rsp_status_q;
        rsp_timeout_d = rsp_timeout_q;
        poll_cnt_d    = poll_cnt_q;
        ctrl_d        = ctrl_q;
        io_d          = io_q;
        mem_d         = mem_q;
        extra_d       = extra_q;

        case (state_q)
            IDLE: begin
                if (bus.cmd_valid && cmd_ready_q) begin
                    ctrl_d  = bus.cmd_ctrl;
                    io_d    = bus.cmd_io_addr;
                    mem_d   = bus.cmd_mem_addr;
                    extra_d = bus.cmd_extra;
                    state_d = WR_IO;
                end
            end
            WR_IO:    state_d = WR_MEM;
            WR_MEM:   state_d = WR_EXTRA;
            WR_EXTRA: state_d = WR_CTRL;
            WR_CTRL:  state_d = RD_INTR;
            RD_INTR:  state_d = RD_WAIT;
            RD_WAIT: begin
                rsp_status_d = bus.rdata;
                poll_cnt_d   = poll_cnt_inc;
                if (bus.rdata[DONE_BIT]) begin
                    state_d = CLR_INTR;
                end else if (poll_cnt_inc == CNT_MAX) begin
                    rsp_timeout_d = 1'b1;
                    state_d       = RESP;
                end else begin
                    state_d = RD_INTR;
                end
            end
            CLR_INTR: state_d = RESP;
            RESP: begin
                if (bus.rsp_ready) begin
                    poll_cnt_d    = '0;
                    rsp_timeout_d = 1'b0;
                    state_d       = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Bus and handshake outputs are decoded from the next state so they are registered
    always_comb begin
        addr_d      = '0;
        wr_en_d     = 1'b0;
        rd_en_d     = 1'b0;
        wdata_d     = '0;
        cmd_ready_d = (state_d == IDLE);
        rsp_valid_d = (state_d == RESP);

        case (state_d)
            WR_IO: begin
                addr_d  = ADDR_WIDTH'(REG_IO_ADDR);
                wr_en_d = 1'b1;
                wdata_d = io_d;
            end
            WR_MEM: begin
                addr_d  = ADDR_WIDTH'(REG_MEM_ADDR);
                wr_en_d = 1'b1;
                wdata_d = mem_d;
            end
            WR_EXTRA: begin
                addr_d  = ADDR_WIDTH'(REG_EXTRA);
                wr_en_d = 1'b1;
                wdata_d = extra_d;
            end
            WR_CTRL: begin
                addr_d  = ADDR_WIDTH'(REG_CTRL);
                wr_en_d = 1'b1;
                wdata_d = ctrl_d;
            end
            RD_INTR: begin
                addr_d  = ADDR_WIDTH'(REG_INTR);
                rd_en_d = 1'b1;
            end
            CLR_INTR: begin
                addr_d  = ADDR_WIDTH'(REG_INTR);
                wr_en_d = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.cmd_ready   = cmd_ready_q;
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_status  = rsp_status_q;
    assign bus.rsp_timeout = rsp_timeout_q;
    assign bus.addr        = addr_q;
    assign bus.wr_en       = wr_en_q;
    assign bus.rd_en       = rd_en_q;
    assign bus.wdata       = wdata_q;

endmodule

// File: tb/tb_dma_cfg_master.sv
// tb/tb_dma_cfg_master.sv - directed bench for dma_cfg_master with a one-cycle-latency register responder
module tb_dma_cfg_master;

    logic clk;
    logic rst_n;

    dma_cfg_master_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    dma_cfg_master #(
        .ADDR_WIDTH(32),
        .DATA_WIDTH(32),
        .POLL_LIMIT(4),
        .DONE_BIT  (0)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          cyc = 0;
    logic [31:0] rd_seq[$];
    logic [31:0] rd_default = 32'h0;
    logic [63:0] wr_log[$];
    int          rd_log[$];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus.wr_en) wr_log.push_back({bus.addr, bus.wdata});
        if (bus.rd_en) begin
            rd_log.push_back(cyc);
            bus.rdata <= (rd_seq.size() > 0) ? rd_seq.pop_front() : rd_default;
        end
    end

    int n_checks = 0;
    int n_fail   = 0;
    int c0       = 0;
    int rsp_cyc;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_wr(input int idx, input logic [31:0] a, input logic [31:0] d);
        logic [63:0] obs;
        obs = (idx < wr_log.size()) ? wr_log[idx] : 64'hFFFF_FFFF_FFFF_FFFF;
        chk($sformatf("wr%0d", idx), obs, {a, d});
    endtask

    task automatic chk_rd(input int idx, input int exp_cycle);
        int obs;
        obs = (idx < rd_log.size()) ? rd_log[idx] - c0 + 1 : -1;
        chk($sformatf("rd%0d_cycle", idx), 64'(obs), 64'(exp_cycle));
    endtask

    task automatic clear_logs();
        wr_log.delete();
        rd_log.delete();
        rd_seq.delete();
    endtask

    task automatic send_cmd(input logic [31:0] c, input logic [31:0] io,
                            input logic [31:0] mem, input logic [31:0] ex);
        @(negedge clk);
        bus.cmd_ctrl     = c;
        bus.cmd_io_addr  = io;
        bus.cmd_mem_addr = mem;
        bus.cmd_extra    = ex;
        bus.cmd_valid    = 1'b1;
        @(posedge clk);
        #1;
        c0 = cyc;
        bus.cmd_valid    = 1'b0;
        bus.cmd_ctrl     = 32'hDEAD_0001;
        bus.cmd_io_addr  = 32'hDEAD_0002;
        bus.cmd_mem_addr = 32'hDEAD_0003;
        bus.cmd_extra    = 32'hDEAD_0004;
    endtask

    task automatic wait_rsp(output int k);
        k = -1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (bus.rsp_valid) begin
                k = cyc - c0 + 1;
                break;
            end
        end
    endtask

    initial begin
        rst_n            = 1'b0;
        bus.cmd_valid    = 1'b0;
        bus.cmd_ctrl     = '0;
        bus.cmd_io_addr  = '0;
        bus.cmd_mem_addr = '0;
        bus.cmd_extra    = '0;
        bus.rsp_ready    = 1'b1;
        bus.rdata        = '0;

        // Reset values
        repeat (2) @(negedge clk);
        chk("rst_cmd_ready", 64'(bus.cmd_ready), 64'h1);
        chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'h0);
        chk("rst_rsp_status", 64'(bus.rsp_status), 64'h0);
        chk("rst_rsp_timeout", 64'(bus.rsp_timeout), 64'h0);
        chk("rst_addr", 64'(bus.addr), 64'h0);
        chk("rst_wr_en", 64'(bus.wr_en), 64'h0);
        chk("rst_rd_en", 64'(bus.rd_en), 64'h0);
        chk("rst_wdata", 64'(bus.wdata), 64'h0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_cmd_ready", 64'(bus.cmd_ready), 64'h1);
        chk("idle_strobes", 64'({bus.wr_en, bus.rd_en}), 64'h0);

        // Nominal: done on first poll
        clear_logs();
        rd_seq.push_back(32'h1);
        send_cmd(32'h1, 32'h1000, 32'h2000, 32'hAB);
        wait_rsp(rsp_cyc);
        chk("nom_rsp_cycle", 64'(rsp_cyc), 64'd8);
        chk("nom_status", 64'(bus.rsp_status), 64'h1);
        chk("nom_timeout", 64'(bus.rsp_timeout), 64'h0);
        chk("nom_cmd_ready_busy", 64'(bus.cmd_ready), 64'h0);
        chk("nom_wr_count", 64'(wr_log.size()), 64'd5);
        chk_wr(0, 32'h408, 32'h1000);
        chk_wr(1, 32'h40C, 32'h2000);
        chk_wr(2, 32'h410, 32'hAB);
        chk_wr(3, 32'h404, 32'h1);
        chk_wr(4, 32'h400, 32'h0);
        chk("nom_rd_count", 64'(rd_log.size()), 64'd1);
        chk_rd(0, 5);
        @(negedge clk);
        chk("nom_cmd_ready_after", 64'(bus.cmd_ready), 64'h1);
        chk("nom_rsp_valid_after", 64'(bus.rsp_valid), 64'h0);

        // Delayed done: 0, 0, 1
        clear_logs();
        rd_seq.push_back(32'h0);
        rd_seq.push_back(32'h0);
        rd_seq.push_back(32'h1);
        send_cmd(32'h3, 32'h1111, 32'h2222, 32'h33);
        wait_rsp(rsp_cyc);
        chk("dly_rsp_cycle", 64'(rsp_cyc), 64'd12);
        chk("dly_status", 64'(bus.rsp_status), 64'h1);
        chk("dly_timeout", 64'(bus.rsp_timeout), 64'h0);
        chk("dly_rd_count", 64'(rd_log.size()), 64'd3);
        chk_rd(0, 5);
        chk_rd(1, 7);
        chk_rd(2, 9);
        chk("dly_wr_count", 64'(wr_log.size()), 64'd5);
        chk_wr(3, 32'h404, 32'h3);
        chk_wr(4, 32'h400, 32'h0);
        @(negedge clk);

        // Timeout: interrupt register never shows done
        clear_logs();
        rd_default = 32'h2;
        send_cmd(32'h5, 32'hA0, 32'hB0, 32'hC0);
        wait_rsp(rsp_cyc);
        chk("to_rsp_cycle", 64'(rsp_cyc), 64'd13);
        chk("to_status", 64'(bus.rsp_status), 64'h2);
        chk("to_timeout", 64'(bus.rsp_timeout), 64'h1);
        chk("to_rd_count", 64'(rd_log.size()), 64'd4);
        chk_rd(3, 11);
        chk("to_wr_count", 64'(wr_log.size()), 64'd4);
        chk_wr(3, 32'h404, 32'h5);
        @(negedge clk);
        chk("to_timeout_cleared", 64'(bus.rsp_timeout), 64'h0);
        chk("to_cmd_ready_after", 64'(bus.cmd_ready), 64'h1);

        // Backpressure on the response port
        clear_logs();
        rd_default    = 32'h1;
        bus.rsp_ready = 1'b0;
        send_cmd(32'h7, 32'h7000, 32'h8000, 32'h9);
        wait_rsp(rsp_cyc);
        chk("bp_rsp_cycle", 64'(rsp_cyc), 64'd8);
        bus.cmd_valid    = 1'b1;
        bus.cmd_ctrl     = 32'h11;
        bus.cmd_io_addr  = 32'h5555;
        bus.cmd_mem_addr = 32'h6666;
        bus.cmd_extra    = 32'h77;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("bp_hold%0d", i),
                {61'h0, bus.rsp_valid, bus.cmd_ready, bus.rsp_timeout}, 64'h4);
            chk($sformatf("bp_status%0d", i), 64'(bus.rsp_status), 64'h1);
        end
        chk("bp_no_writes", 64'(wr_log.size()), 64'd5);
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("bp_release", {62'h0, bus.cmd_ready, bus.rsp_valid}, 64'h2);
        chk("bp_no_strobe_idle", 64'({bus.wr_en, bus.rd_en}), 64'h0);
        @(posedge clk);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        chk("bp_accept_ready", 64'(bus.cmd_ready), 64'h0);
        chk("bp_accept_bus", {bus.addr, bus.wdata}, {32'h408, 32'h5555});
        chk("bp_accept_wr_en", 64'(bus.wr_en), 64'h1);
        c0 = cyc;
        wait_rsp(rsp_cyc);
        chk("bp_second_rsp_cycle", 64'(rsp_cyc), 64'd8);
        @(negedge clk);

        // Reset asserted while writing mem_address
        clear_logs();
        send_cmd(32'h9, 32'h9000, 32'hA000, 32'hBB);
        @(posedge clk);
        #2;
        chk("mid_wr_mem_bus", {bus.addr, bus.wdata}, {32'h40C, 32'hA000});
        rst_n = 1'b0;
        #1;
        chk("mid_rst_wr_en", 64'(bus.wr_en), 64'h0);
        chk("mid_rst_addr", 64'(bus.addr), 64'h0);
        chk("mid_rst_cmd_ready", 64'(bus.cmd_ready), 64'h1);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_idle", {62'h0, bus.cmd_ready, bus.wr_en}, 64'h2);
        clear_logs();
        send_cmd(32'hC, 32'hC100, 32'hC200, 32'hC3);
        wait_rsp(rsp_cyc);
        chk("post_rst_rsp_cycle", 64'(rsp_cyc), 64'd8);
        chk("post_rst_wr_count", 64'(wr_log.size()), 64'd5);
        chk_wr(0, 32'h408, 32'hC100);
        chk_wr(1, 32'h40C, 32'hC200);
        chk_wr(2, 32'h410, 32'hC3);
        chk_wr(3, 32'h404, 32'hC);
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
